// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : midi_pkg
//  Purpose   : Shared types and constants for the MIDI voice scheduler block.
//              Slot layout, scheduler state encoding and a width helper.
//  Revision  : 1.0  initial release
// ============================================================================
package midi_pkg;

  // Voice slot count, matches the upstream burst collector.
  localparam int NUM_VOICES = 5;

  // One burst slot as delivered on the flat bus: {note[15:8], velocity[7:0]}.
  typedef struct packed {
    logic [7:0] note;
    logic [7:0] velocity;
  } note_slot_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_COMMIT = 3'd4
  } sched_state_t;

  // Bit width needed to index n items, never less than 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/midi_req_timeout.sv
`default_nettype none
// ============================================================================
//  Module    : midi_req_timeout
//  Purpose   : Loadable down-counter guarding one outstanding engine request.
//              Loaded with TIMEOUT-1 when a request is accepted, counts down
//              while the scheduler waits, and flags expiry on the last cycle
//              of the wait window (so a wait lasts at most TIMEOUT cycles).
//  Ports     : clk      in  system clock
//              rst_n    in  async active-low reset
//              load     in  request accepted: restart the window
//              count_en in  scheduler is waiting for a response
//              expired  out window exhausted this cycle (only while count_en)
//  Revision  : 1.0  initial release
// ============================================================================
module midi_req_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count_en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = count_en && (count == '0);

endmodule
`default_nettype wire

// File: rtl/midi_voice_scheduler.sv
`default_nettype none
// ============================================================================
//  Module    : midi_voice_scheduler
//  Purpose   : Walks the burst note slots, sends each active voice to the
//              shared note->phase-increment engine one at a time, collects the
//              responses into a shadow table and publishes the whole table and
//              active mask in one cycle.
//  Ports     : clk_in, rst_n_in           clock, async active-low reset
//              burst_notes_in, note_on_in slot contents and active mask
//              burst_refresh_in           pulse: slots changed
//              req_*                      valid/ready request to the engine
//              resp_valid_in/resp_data_in engine result for outstanding request
//              voice_incr_out/_active_out published table and mask
//              table_update_out           pulse when a table is published
//              busy_out                   pass in progress
//              timeout_err_out            sticky: a response timed out
//  Revision  : 1.0  initial release
// ============================================================================
module midi_voice_scheduler
  import midi_pkg::*;
#(
  parameter  int NUM_VOICES   = midi_pkg::NUM_VOICES,
  parameter  int INCR_W       = 32,
  parameter  int RESP_TIMEOUT = 1024,
  localparam int VOICE_W      = clog2_min1(NUM_VOICES)
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [16*NUM_VOICES-1:0]     burst_notes_in,
  input  logic [NUM_VOICES-1:0]        note_on_in,
  input  logic                         burst_refresh_in,
  output logic                         req_valid_out,
  input  logic                         req_ready_in,
  output logic [VOICE_W-1:0]           req_voice_out,
  output logic [7:0]                   req_note_out,
  output logic [7:0]                   req_velocity_out,
  input  logic                         resp_valid_in,
  input  logic [INCR_W-1:0]            resp_data_in,
  output logic [INCR_W*NUM_VOICES-1:0] voice_incr_out,
  output logic [NUM_VOICES-1:0]        voice_active_out,
  output logic                         table_update_out,
  output logic                         busy_out,
  output logic                         timeout_err_out
);

  // idx must be able to hold NUM_VOICES itself ("past the last voice").
  localparam int IDX_W = $clog2(NUM_VOICES + 1);

  sched_state_t          state, state_next;
  logic [IDX_W-1:0]      idx;
  logic [VOICE_W-1:0]    cur;
  logic                  past_last;
  note_slot_t            snap [NUM_VOICES];
  logic [NUM_VOICES-1:0] snap_mask;
  logic [INCR_W-1:0]     shadow [NUM_VOICES];
  logic                  pending;
  logic                  accept;
  logic                  in_wait;
  logic                  expired;
  logic                  load_snap;
  logic                  rerun;

  assign past_last = (idx >= IDX_W'(NUM_VOICES));
  // Clamp so the array reads stay in range on the past-the-end SCAN cycle.
  assign cur       = past_last ? '0 : VOICE_W'(idx);
  assign rerun     = pending || burst_refresh_in;

  midi_req_timeout #(
    .TIMEOUT (RESP_TIMEOUT)
  ) u_timeout (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .load     (accept),
    .count_en (in_wait),
    .expired  (expired)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    in_wait    = 1'b0;
    load_snap  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (burst_refresh_in) begin
          state_next = ST_SCAN;
          load_snap  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (past_last) begin
          state_next = ST_COMMIT;
        end else if (snap_mask[cur]) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (req_ready_in) begin
          state_next = ST_WAIT;
          accept     = 1'b1;
        end
      end
      ST_WAIT: begin
        in_wait = 1'b1;
        if (resp_valid_in || expired) begin
          state_next = ST_SCAN;
        end
      end
      ST_COMMIT: begin
        // A refresh landing on the commit cycle counts as pending.
        if (rerun) begin
          state_next = ST_SCAN;
          load_snap  = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Snapshot, shadow table and published outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idx              <= '0;
      snap_mask        <= '0;
      pending          <= 1'b0;
      voice_incr_out   <= '0;
      voice_active_out <= '0;
      table_update_out <= 1'b0;
      timeout_err_out  <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        snap[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      table_update_out <= 1'b0;

      // Refreshes during a pass coalesce into one rerun; the snapshot in use
      // is left alone.
      if (burst_refresh_in && (state != ST_IDLE) && (state != ST_COMMIT)) begin
        pending <= 1'b1;
      end

      if (load_snap) begin
        idx       <= '0;
        snap_mask <= note_on_in;
        for (int i = 0; i < NUM_VOICES; i++) begin
          snap[i] <= burst_notes_in[i*16 +: 16];
        end
      end

      case (state)
        ST_SCAN: begin
          if (!past_last && !snap_mask[cur]) begin
            shadow[cur] <= '0;
            idx         <= idx + 1'b1;
          end
        end
        ST_WAIT: begin
          // A response on the final window cycle still wins over the timeout.
          if (resp_valid_in) begin
            shadow[cur] <= resp_data_in;
            idx         <= idx + 1'b1;
          end else if (expired) begin
            shadow[cur]     <= '0;
            timeout_err_out <= 1'b1;
            idx             <= idx + 1'b1;
          end
        end
        ST_COMMIT: begin
          pending          <= 1'b0;
          table_update_out <= 1'b1;
          voice_active_out <= snap_mask;
          for (int i = 0; i < NUM_VOICES; i++) begin
            voice_incr_out[i*INCR_W +: INCR_W] <= shadow[i];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_valid_out    = (state == ST_ISSUE);
  assign req_voice_out    = cur;
  assign req_note_out     = snap[cur].note;
  assign req_velocity_out = snap[cur].velocity;
  assign busy_out         = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_midi_voice_scheduler.sv
`default_nettype none
// ============================================================================
//  Module    : tb_midi_voice_scheduler
//  Purpose   : Self-checking bench for midi_voice_scheduler. A behavioural
//              engine answers requests; expected tables, request order and
//              refresh-to-update latency come from a voice-level model.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_midi_voice_scheduler;

  localparam int NV = 5;
  localparam int IW = 32;
  localparam int TO = 16;
  localparam int VW = 3;

  logic              clk = 1'b0;
  logic              rst_n_in;
  logic [16*NV-1:0]  burst_notes_in;
  logic [NV-1:0]     note_on_in;
  logic              burst_refresh_in;
  logic              req_valid_out;
  logic              req_ready_in;
  logic [VW-1:0]     req_voice_out;
  logic [7:0]        req_note_out;
  logic [7:0]        req_velocity_out;
  logic              resp_valid_in;
  logic [IW-1:0]     resp_data_in;
  logic [IW*NV-1:0]  voice_incr_out;
  logic [NV-1:0]     voice_active_out;
  logic              table_update_out;
  logic              busy_out;
  logic              timeout_err_out;

  midi_voice_scheduler #(
    .NUM_VOICES   (NV),
    .INCR_W       (IW),
    .RESP_TIMEOUT (TO)
  ) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n_in),
    .burst_notes_in   (burst_notes_in),
    .note_on_in       (note_on_in),
    .burst_refresh_in (burst_refresh_in),
    .req_valid_out    (req_valid_out),
    .req_ready_in     (req_ready_in),
    .req_voice_out    (req_voice_out),
    .req_note_out     (req_note_out),
    .req_velocity_out (req_velocity_out),
    .resp_valid_in    (resp_valid_in),
    .resp_data_in     (resp_data_in),
    .voice_incr_out   (voice_incr_out),
    .voice_active_out (voice_active_out),
    .table_update_out (table_update_out),
    .busy_out         (busy_out),
    .timeout_err_out  (timeout_err_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Slot model.
  logic [7:0]    m_note [NV];
  logic [7:0]    m_vel  [NV];
  logic [NV-1:0] m_mask;

  // Engine configuration (written by the main sequence).
  int cfg_delay       = 1;
  int cfg_stall_voice = -1;
  int cfg_stall_n     = 0;
  int cfg_drop_voice  = -1;
  int stray_cnt       = 0;

  // Engine bookkeeping (written only by the engine).
  int          req_count    = 0;
  int          valid_cycles = 0;
  int          unstable     = 0;
  logic [18:0] req_log [256];
  int          stray_seen   = 0;
  int          cd           = 0;
  bit          outstanding  = 1'b0;
  bit          out_drop     = 1'b0;
  logic [31:0] out_val      = '0;
  int          cur_stall    = 0;
  logic [18:0] held         = '0;

  // Update pulse counter (written only by the monitor).
  int upd_count = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- engine
  // Decides ready and responses on the falling edge so the DUT sees stable
  // inputs at the next rising edge.
  initial begin
    req_ready_in  = 1'b1;
    resp_valid_in = 1'b0;
    resp_data_in  = '0;
    forever begin
      @(negedge clk);
      resp_valid_in = 1'b0;
      if (!rst_n_in) begin
        outstanding = 1'b0;
        cur_stall   = 0;
      end else begin
        if (outstanding) begin
          cd--;
          if (cd <= 0) begin
            outstanding = 1'b0;
            if (!out_drop) begin
              resp_valid_in = 1'b1;
              resp_data_in  = out_val;
            end
          end
        end
        if (stray_cnt != stray_seen) begin
          stray_seen    = stray_cnt;
          resp_valid_in = 1'b1;
          resp_data_in  = 32'hDEAD_BEEF;
        end
        if (req_valid_out) begin
          valid_cycles++;
          if (cur_stall == 0) begin
            held = {req_voice_out, req_note_out, req_velocity_out};
          end else if ({req_voice_out, req_note_out, req_velocity_out} !== held) begin
            unstable++;
          end
          if ((int'(req_voice_out) == cfg_stall_voice) && (cur_stall < cfg_stall_n)) begin
            req_ready_in = 1'b0;
            cur_stall++;
          end else begin
            req_ready_in = 1'b1;
            req_log[req_count[7:0]] = {req_voice_out, req_note_out, req_velocity_out};
            req_count++;
            outstanding = 1'b1;
            cd          = cfg_delay;
            out_val     = 32'(req_note_out) * 32'd1000;
            out_drop    = (int'(req_voice_out) == cfg_drop_voice);
            cur_stall   = 0;
          end
        end else begin
          req_ready_in = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (table_update_out) upd_count++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- helpers
  function automatic logic [31:0] exp_incr(input int i);
    if (!m_mask[i] || (i == cfg_drop_voice)) return 32'd0;
    return 32'(m_note[i]) * 32'd1000;
  endfunction

  task automatic drive_slots();
    for (int i = 0; i < NV; i++) burst_notes_in[i*16 +: 16] = {m_note[i], m_vel[i]};
    note_on_in = m_mask;
  endtask

  task automatic rand_slots(input logic [NV-1:0] mask);
    for (int i = 0; i < NV; i++) begin
      m_note[i] = 8'($urandom_range(0, 127));
      m_vel[i]  = 8'($urandom_range(0, 127));
    end
    m_mask = mask;
  endtask

  task automatic pulse_refresh();
    @(negedge clk);
    burst_refresh_in = 1'b1;
    @(negedge clk);
    burst_refresh_in = 1'b0;
  endtask

  // Counts rising edges after the refresh edge until the update pulse shows.
  task automatic wait_update(input int max, output int lat);
    lat = -1;
    for (int n = 1; n <= max; n++) begin
      @(posedge clk);
      #1;
      if (table_update_out) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) chk("update_seen", 64'(table_update_out), 64'(1));
  endtask

  // One full refresh pass checked against the voice-level model.
  task automatic run_pass(input string tag);
    int          lat, exp_lat, n_exp, base, vbase, ubase, k, stall_extra;
    logic [31:0] exp_tab [NV];
    exp_lat     = 2;
    n_exp       = 0;
    stall_extra = 0;
    for (int i = 0; i < NV; i++) begin
      if (m_mask[i]) begin
        exp_lat += 2 + ((i == cfg_drop_voice) ? TO : cfg_delay);
        if (i == cfg_stall_voice) begin
          exp_lat    += cfg_stall_n;
          stall_extra = cfg_stall_n;
        end
        n_exp++;
      end else begin
        exp_lat += 1;
      end
      exp_tab[i] = exp_incr(i);
    end
    drive_slots();
    base  = req_count;
    vbase = valid_cycles;
    ubase = upd_count;
    pulse_refresh();
    wait_update(400, lat);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    for (int i = 0; i < NV; i++)
      chk($sformatf("%s_incr%0d", tag, i), 64'(voice_incr_out[i*IW +: IW]), 64'(exp_tab[i]));
    chk({tag, "_active"}, 64'(voice_active_out), 64'(m_mask));
    chk({tag, "_nreq"}, 64'(req_count - base), 64'(n_exp));
    k = base;
    for (int i = 0; i < NV; i++) begin
      if (m_mask[i]) begin
        chk($sformatf("%s_req%0d", tag, i), 64'(req_log[k[7:0]]), 64'({i[2:0], m_note[i], m_vel[i]}));
        k++;
      end
    end
    chk({tag, "_valid_cycles"}, 64'(valid_cycles - vbase), 64'(n_exp + stall_extra));
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_one_update"}, 64'(upd_count - ubase), 64'(1));
    chk({tag, "_idle"}, 64'(busy_out), 64'(0));
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    int          lat, ubase, vbase, base, n;
    logic [31:0] exp_a [NV];
    logic [31:0] exp_b [NV];
    logic [NV-1:0] mask_b;

    rst_n_in         = 1'b0;
    burst_refresh_in = 1'b0;
    burst_notes_in   = '0;
    note_on_in       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", 64'(req_valid_out), 64'(0));
    chk("rst_busy", 64'(busy_out), 64'(0));
    chk("rst_update", 64'(table_update_out), 64'(0));
    chk("rst_err", 64'(timeout_err_out), 64'(0));
    chk("rst_active", 64'(voice_active_out), 64'(0));
    chk("rst_incr_any", 64'(|voice_incr_out), 64'(0));
    chk("rst_req_fields", 64'({req_voice_out, req_note_out, req_velocity_out}), 64'(0));
    @(negedge clk);
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk);

    // Sparse mask, notes 60/64/67 on voices 0/2/4.
    rand_slots(5'b10101);
    m_note[0] = 8'd60;
    m_note[2] = 8'd64;
    m_note[4] = 8'd67;
    run_pass("t1");

    // All voices active, one-cycle response: 17-cycle latency.
    rand_slots(5'b11111);
    run_pass("t_lat");

    // Ready held low 10 cycles on voice 3.
    rand_slots(5'($urandom) | 5'b01000);
    cfg_stall_voice = 3;
    cfg_stall_n     = 10;
    run_pass("t2");
    chk("t2_stable", 64'(unstable), 64'(0));
    cfg_stall_voice = -1;
    cfg_stall_n     = 0;

    // Voice 1 never answered.
    rand_slots(5'($urandom) | 5'b00010);
    cfg_drop_voice = 1;
    chk("t3_err_before", 64'(timeout_err_out), 64'(0));
    run_pass("t3");
    chk("t3_err_set", 64'(timeout_err_out), 64'(1));
    cfg_drop_voice = -1;
    ubase = upd_count;
    stray_cnt++;
    repeat (4) @(posedge clk);
    #1;
    chk("t3_stray_incr1", 64'(voice_incr_out[1*IW +: IW]), 64'(0));
    chk("t3_stray_no_update", 64'(upd_count - ubase), 64'(0));
    chk("t3_stray_idle", 64'(busy_out), 64'(0));
    rand_slots(5'b11111);
    run_pass("t3_clean");
    chk("t3_err_sticky", 64'(timeout_err_out), 64'(1));

    // Three refreshes during one pass coalesce into one rerun.
    rand_slots(5'b11111);
    for (int i = 0; i < NV; i++) exp_a[i] = exp_incr(i);
    drive_slots();
    ubase = upd_count;
    pulse_refresh();
    repeat (2) @(negedge clk);
    mask_b = 5'($urandom) | 5'b00100;
    rand_slots(mask_b);
    for (int i = 0; i < NV; i++) exp_b[i] = exp_incr(i);
    drive_slots();
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      burst_refresh_in = 1'b1;
      @(negedge clk);
      burst_refresh_in = 1'b0;
      @(negedge clk);
    end
    wait_update(100, lat);
    for (int i = 0; i < NV; i++)
      chk($sformatf("t4_first_incr%0d", i), 64'(voice_incr_out[i*IW +: IW]), 64'(exp_a[i]));
    chk("t4_first_active", 64'(voice_active_out), 64'(5'b11111));
    wait_update(200, lat);
    for (int i = 0; i < NV; i++)
      chk($sformatf("t4_second_incr%0d", i), 64'(voice_incr_out[i*IW +: IW]), 64'(exp_b[i]));
    chk("t4_second_active", 64'(voice_active_out), 64'(mask_b));
    repeat (30) @(posedge clk);
    #1;
    chk("t4_two_updates", 64'(upd_count - ubase), 64'(2));
    chk("t4_idle", 64'(busy_out), 64'(0));

    // Empty mask: 7-cycle latency, zeros published, no requests.
    rand_slots(5'b00000);
    run_pass("t5");

    // Refresh on the commit cycle of an empty pass gives one extra pass.
    ubase = upd_count;
    vbase = valid_cycles;
    drive_slots();
    pulse_refresh();
    repeat (6) @(negedge clk);
    burst_refresh_in = 1'b1;
    @(negedge clk);
    burst_refresh_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t7_commit_refresh_updates", 64'(upd_count - ubase), 64'(2));
    chk("t7_no_requests", 64'(valid_cycles - vbase), 64'(0));

    // Randomised passes.
    for (int r = 0; r < 6; r++) begin
      rand_slots(5'($urandom));
      cfg_delay = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        cfg_stall_voice = $urandom_range(0, NV - 1);
        cfg_stall_n     = $urandom_range(1, 3);
      end
      run_pass($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_stable", r), 64'(unstable), 64'(0));
      cfg_stall_voice = -1;
      cfg_stall_n     = 0;
    end

    // Reset while waiting for a response.
    cfg_delay = 1;
    rand_slots(5'b11111);
    run_pass("pre_rst");
    cfg_delay = 10;
    rand_slots(5'b11111);
    drive_slots();
    base = req_count;
    pulse_refresh();
    n = 0;
    while ((req_count == base) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("t6_pre_busy", 64'(busy_out), 64'(1));
    chk("t6_pre_err", 64'(timeout_err_out), 64'(1));
    chk("t6_pre_incr_any", 64'(|voice_incr_out), 64'(1));
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("t6_req_valid", 64'(req_valid_out), 64'(0));
    chk("t6_busy", 64'(busy_out), 64'(0));
    chk("t6_incr_any", 64'(|voice_incr_out), 64'(0));
    chk("t6_active", 64'(voice_active_out), 64'(0));
    chk("t6_update", 64'(table_update_out), 64'(0));
    chk("t6_err", 64'(timeout_err_out), 64'(0));
    repeat (2) @(negedge clk);
    rst_n_in  = 1'b1;
    cfg_delay = 1;
    @(negedge clk);
    rand_slots(5'($urandom) | 5'b00001);
    run_pass("t6_clean");
    chk("t6_clean_err", 64'(timeout_err_out), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
